// File: rtl/fft_mag_peak_scan_pkg.sv
// ---------------------------------------------------------------------------
// fft_mag_peak_scan_pkg
//
// Purpose:
//   Shared constants, state encoding and the output saturation helper for the
//   FFT bin magnitude / peak scanner (fft_mag_peak_scan) and its combinational
//   magnitude block (fft_bin_mag).
//
// Contents:
//   NBINS_DEF / DW_DEF  default bin count and bin component width
//   IDX_W               bin index width, log2(NBINS_DEF)
//   MAG_W               full magnitude width (sum of two 6-bit squares)
//   OUT_W / OUT_SHIFT   streamed magnitude width and its bit offset into mag
//   TRUNC_*             slice of |v| that feeds the squarers, given as
//                       offsets below DW: |v|[DW-2 : DW-7]
//   state_t             scanner FSM states
//   sat_out()           full magnitude -> 8-bit streamed magnitude
// ---------------------------------------------------------------------------
package fft_mag_peak_scan_pkg;

    localparam int NBINS_DEF    = 8;
    localparam int DW_DEF       = 12;
    localparam int IDX_W        = $clog2(NBINS_DEF);

    // |v| is at most 2^(DW-1)-1, so its top bit is always zero; the slice
    // starts one below it and keeps the six most significant live bits.
    localparam int TRUNC_HI_OFS = 2;
    localparam int TRUNC_LO_OFS = 7;
    localparam int TRUNC_W      = TRUNC_LO_OFS - TRUNC_HI_OFS + 1;

    // Two 6-bit squares summed: 2 * 63^2 = 7938 fits in 13 bits.
    localparam int MAG_W        = 2 * TRUNC_W + 1;
    localparam int OUT_W        = 8;
    localparam int OUT_SHIFT    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Streamed value is mag[11:4]; any magnitude with the top bit set is
    // beyond that window and clips to all ones.
    function automatic logic [OUT_W-1:0] sat_out(input logic [MAG_W-1:0] mag);
        if (mag[MAG_W-1]) begin
            return '1;
        end
        return mag[OUT_SHIFT+OUT_W-1:OUT_SHIFT];
    endfunction

endpackage

// File: rtl/fft_mag_peak_scan_if.sv
// ---------------------------------------------------------------------------
// fft_mag_peak_scan_if
//
// Purpose:
//   Magnitude stream from the peak scanner to its consumer.
//
// Handshake:
//   A beat transfers on a rising clk edge where out_valid && out_ready.
//   While out_valid is high and out_ready is low, the producer holds
//   out_data/out_idx/out_last stable and keeps out_valid high. out_valid
//   never depends combinationally on out_ready.
//
// Signals:
//   out_valid  producer -> consumer  beat present
//   out_ready  consumer -> producer  consumer takes the beat this edge
//   out_data   producer -> consumer  saturated 8-bit magnitude of bin out_idx
//   out_idx    producer -> consumer  bin index of the beat
//   out_last   producer -> consumer  beat carries the final bin of the frame
// ---------------------------------------------------------------------------
interface fft_mag_peak_scan_if #(
    parameter int IW = fft_mag_peak_scan_pkg::IDX_W
) ();

    logic                                   out_valid;
    logic                                   out_ready;
    logic [fft_mag_peak_scan_pkg::OUT_W-1:0] out_data;
    logic [IW-1:0]                          out_idx;
    logic                                   out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_idx,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_idx,
        input  out_last
    );

endinterface

// File: rtl/fft_mag_peak_scan_mag.sv
// ---------------------------------------------------------------------------
// fft_bin_mag
//
// Purpose:
//   Purely combinational approximate squared magnitude of one complex bin.
//   Each component is made absolute (the most negative code saturates to the
//   most positive), truncated to its six most significant live bits, squared,
//   and the two squares are summed. The 8-bit streamed form is also produced.
//
// Ports:
//   re, im  in   DW-bit signed components
//   mag     out  MAG_W-bit approximate |x|^2 (max 7938)
//   data    out  OUT_W-bit saturated magnitude, mag[12] ? 8'hFF : mag[11:4]
// ---------------------------------------------------------------------------
module fft_bin_mag
    import fft_mag_peak_scan_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic signed [DW-1:0] re,
    input  logic signed [DW-1:0] im,
    output logic [MAG_W-1:0]     mag,
    output logic [OUT_W-1:0]     data
);

    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam int            T_HI    = DW - TRUNC_HI_OFS;
    localparam int            T_LO    = DW - TRUNC_LO_OFS;

    // -2^(DW-1) has no positive counterpart in DW bits; clamp it instead of
    // letting the negation wrap back to itself.
    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] v);
        if (v == NEG_MIN) begin
            return POS_MAX;
        end
        if (v[DW-1]) begin
            return -v;
        end
        return v;
    endfunction

    logic [DW-1:0]        abs_re;
    logic [DW-1:0]        abs_im;
    logic [TRUNC_W-1:0]   t_re;
    logic [TRUNC_W-1:0]   t_im;
    logic [2*TRUNC_W-1:0] sq_re;
    logic [2*TRUNC_W-1:0] sq_im;

    always_comb begin
        abs_re = abs_sat(re);
        abs_im = abs_sat(im);
        t_re   = abs_re[T_HI:T_LO];
        t_im   = abs_im[T_HI:T_LO];
        sq_re  = {{TRUNC_W{1'b0}}, t_re} * {{TRUNC_W{1'b0}}, t_re};
        sq_im  = {{TRUNC_W{1'b0}}, t_im} * {{TRUNC_W{1'b0}}, t_im};
        mag    = {1'b0, sq_re} + {1'b0, sq_im};
        data   = sat_out(mag);
    end

endmodule

// File: rtl/fft_mag_peak_scan.sv
// ---------------------------------------------------------------------------
// fft_mag_peak_scan
//
// Purpose:
//   Downstream consumer of the 8-point FFT core. On a start pulse the NBINS
//   complex bins are captured; each bin's approximate squared magnitude is
//   then computed in turn through one shared fft_bin_mag and streamed as one
//   8-bit beat per bin. The largest bin (index and full-width magnitude) is
//   tracked and a done pulse closes the scan.
//
//   Per bin the FSM spends one LOAD cycle (compute, register, peak update)
//   and at least one SEND cycle (beat presented), so the stream peaks at one
//   beat per two cycles and a frame with a ready consumer takes 18 cycles
//   counting the start cycle and the done cycle.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       single-cycle request; honoured only in IDLE
//   bins_re     packed real parts, bin k at [k*DW +: DW]
//   bins_im     packed imaginary parts, same packing
//   busy        high from the cycle after an accepted start through done
//   out_if      magnitude stream (master side, see fft_mag_peak_scan_if)
//   peak_idx    index of the largest bin of the last completed scan
//   peak_mag    full-width magnitude of that bin
//   done        one-cycle pulse after the last beat is accepted
//   dbg_state   current FSM state
// ---------------------------------------------------------------------------
module fft_mag_peak_scan
    import fft_mag_peak_scan_pkg::*;
#(
    parameter int NBINS   = NBINS_DEF,
    parameter int DW      = DW_DEF,
    parameter bit SKIP_DC = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NBINS*DW-1:0]     bins_re,
    input  logic [NBINS*DW-1:0]     bins_im,
    output logic                    busy,
    fft_mag_peak_scan_if.master     out_if,
    output logic [$clog2(NBINS)-1:0] peak_idx,
    output logic [MAG_W-1:0]        peak_mag,
    output logic                    done,
    output state_t                  dbg_state
);

    localparam int IW = $clog2(NBINS);

    state_t              state_q;
    state_t              state_d;
    logic [NBINS*DW-1:0] bins_re_q;
    logic [NBINS*DW-1:0] bins_im_q;
    logic [IW-1:0]       idx_q;
    logic [OUT_W-1:0]    data_q;
    logic [IW-1:0]       peak_idx_q;
    logic [MAG_W-1:0]    peak_mag_q;

    // FSM strobes
    logic capture;
    logic load_en;
    logic advance;
    logic send_valid;
    logic send_last;

    // Shared magnitude datapath, fed by the bin the index currently selects
    logic signed [DW-1:0] cur_re;
    logic signed [DW-1:0] cur_im;
    logic [MAG_W-1:0]     bin_mag;
    logic [OUT_W-1:0]     bin_data;
    logic                 peak_upd;

    assign cur_re = bins_re_q[int'(idx_q)*DW +: DW];
    assign cur_im = bins_im_q[int'(idx_q)*DW +: DW];

    fft_bin_mag #(
        .DW (DW)
    ) u_bin_mag (
        .re   (cur_re),
        .im   (cur_im),
        .mag  (bin_mag),
        .data (bin_data)
    );

    // Strictly greater keeps the earlier (lower) index on ties; the DC bin
    // can be left out of the search while still being streamed.
    assign peak_upd = (bin_mag > peak_mag_q) && !(SKIP_DC && (idx_q == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bins_re_q  <= '0;
            bins_im_q  <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            peak_idx_q <= '0;
            peak_mag_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                bins_re_q  <= bins_re;
                bins_im_q  <= bins_im;
                idx_q      <= '0;
                peak_idx_q <= '0;
                peak_mag_q <= '0;
            end
            if (load_en) begin
                data_q <= bin_data;
                if (peak_upd) begin
                    peak_mag_q <= bin_mag;
                    peak_idx_q <= idx_q;
                end
            end
            if (advance) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        load_en    = 1'b0;
        advance    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        send_valid = 1'b0;
        send_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_en = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // idx_q and data_q do not change until the beat is taken,
                // which keeps the beat stable across stalls.
                send_valid = 1'b1;
                send_last  = (idx_q == IW'(NBINS - 1));
                if (out_if.out_ready) begin
                    if (send_last) begin
                        state_d = ST_DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_if.out_valid = send_valid;
    assign out_if.out_last  = send_last;
    assign out_if.out_data  = data_q;
    assign out_if.out_idx   = idx_q;
    assign peak_idx         = peak_idx_q;
    assign peak_mag         = peak_mag_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_fft_mag_peak_scan.sv
// ---------------------------------------------------------------------------
// tb_fft_mag_peak_scan
//
// Directed frames with hand-computed bin magnitudes. Each frame pushes its
// expected beats ({last, idx, data}) into exp_q; a monitor on the falling
// edge compares every presented beat against the head of the queue and pops
// it when the consumer accepts it. Frame tasks check busy, done timing and
// the peak result.
// ---------------------------------------------------------------------------
module tb_fft_mag_peak_scan;
    import fft_mag_peak_scan_pkg::*;

    localparam int NB  = 8;
    localparam int DWB = 12;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [NB*DWB-1:0]   bins_re = '0;
    logic [NB*DWB-1:0]   bins_im = '0;
    logic                busy;
    logic                done;
    logic [2:0]          peak_idx;
    logic [12:0]         peak_mag;
    state_t              dbg_state;

    fft_mag_peak_scan_if out_if ();

    fft_mag_peak_scan #(
        .NBINS   (NB),
        .DW      (DWB),
        .SKIP_DC (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bins_re   (bins_re),
        .bins_im   (bins_im),
        .busy      (busy),
        .out_if    (out_if.master),
        .peak_idx  (peak_idx),
        .peak_mag  (peak_mag),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];
    int          stim_re[NB];
    int          stim_im[NB];
    int          exp_mag[NB];
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: never

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input int m);
        if (m >= 4096) return 8'hFF;
        return 8'((m >> 4) & 255);
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < NB; k++) begin
            stim_re[k] = 0;
            stim_im[k] = 0;
            exp_mag[k] = 0;
        end
    endtask

    task automatic load_and_push();
        for (int k = 0; k < NB; k++) begin
            bins_re[k*DWB +: DWB] = DWB'(stim_re[k]);
            bins_im[k*DWB +: DWB] = DWB'(stim_im[k]);
            exp_q.push_back({(k == NB - 1) ? 1'b1 : 1'b0, 3'(k), exp_data(exp_mag[k])});
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, " busy"},      int'(busy), 0);
        check({name, " out_valid"}, int'(out_if.out_valid), 0);
        check({name, " out_last"},  int'(out_if.out_last), 0);
        check({name, " done"},      int'(done), 0);
        check({name, " out_data"},  int'(out_if.out_data), 0);
        check({name, " out_idx"},   int'(out_if.out_idx), 0);
        check({name, " peak_idx"},  int'(peak_idx), 0);
        check({name, " peak_mag"},  int'(peak_mag), 0);
        check({name, " state"},     int'(dbg_state), int'(ST_IDLE));
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        out_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_if.out_ready = 1'b1;
                1:       out_if.out_ready = 1'($urandom_range(0, 1));
                default: out_if.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [11:0] got;
        if (rst_n && out_if.out_valid) begin
            got = {out_if.out_last, out_if.out_idx, out_if.out_data};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_extra: got %03h expected none", got);
            end else begin
                check($sformatf("beat idx%0d {last,idx,data}", exp_q[0][10:8]),
                      int'(got), int'(exp_q[0]));
                if (out_if.out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- frame driver ----------------
    task automatic run_frame(input string name, input int pk_idx, input int pk_mag,
                             input bit mid_start);
        int cyc;
        bit seen;
        load_and_push();
        @(negedge clk);
        start = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check({name, " busy_after_start"}, int'(busy), 1);
                // Bins were captured; later bus activity must not matter.
                bins_re = {$urandom(), $urandom(), $urandom()};
                bins_im = {$urandom(), $urandom(), $urandom()};
            end
            if (mid_start && cyc == 6) begin
                start = 1'b1;
            end
            if (mid_start && cyc == 7) begin
                start = 1'b0;
                check({name, " busy_mid_start"}, int'(busy), 1);
            end
            if (done) seen = 1'b1;
        end
        check({name, " done_seen"}, int'(seen), 1);
        if (ready_mode == 0) check({name, " done_latency"}, cyc, 17);
        check({name, " beats_left"}, exp_q.size(), 0);
        check({name, " peak_idx"}, int'(peak_idx), pk_idx);
        check({name, " peak_mag"}, int'(peak_mag), pk_mag);
        @(negedge clk);
        check({name, " done_one_cycle"}, int'(done), 0);
        check({name, " busy_after_done"}, int'(busy), 0);
        check({name, " peak_hold"}, int'(peak_mag), pk_mag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int wait_cyc;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Bin 3 re=1024 -> t=32, mag=1024, data=64
        clear_stim();
        stim_re[3] = 1024; exp_mag[3] = 1024;
        run_frame("bin3", 3, 1024, 1'b0);

        // Bin 5 re=-2048 saturates -> t=63, mag=3969, data=248
        clear_stim();
        stim_re[5] = -2048; exp_mag[5] = 3969;
        run_frame("bin5_neg_sat", 5, 3969, 1'b0);

        // Bin 2 re=im=2047 -> 63^2*2=7938, bit12 set, data=255
        clear_stim();
        stim_re[2] = 2047; stim_im[2] = 2047; exp_mag[2] = 7938;
        run_frame("bin2_full", 2, 7938, 1'b0);

        // Tie between bins 1 and 6 (mag 256); large DC bin excluded
        clear_stim();
        stim_re[0] = 2047; exp_mag[0] = 3969;
        stim_re[1] = 512;  exp_mag[1] = 256;
        stim_re[6] = 512;  exp_mag[6] = 256;
        run_frame("tie_skip_dc", 1, 256, 1'b0);

        // Ramp re=k*256, im=-k*256 -> mag=128*k^2, random ready, stray start
        clear_stim();
        for (int k = 0; k < NB; k++) begin
            stim_re[k] = k * 256;
            stim_im[k] = -(k * 256);
        end
        exp_mag = '{0, 128, 512, 1152, 2048, 3200, 4608, 6272};
        ready_mode = 1;
        run_frame("ramp_random_ready", 7, 6272, 1'b1);
        ready_mode = 0;

        // Reset while bin 4 is being presented
        clear_stim();
        stim_re[3] = 1024; exp_mag[3] = 1024;
        load_and_push();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (!(out_if.out_valid && out_if.out_idx == 3'd4) && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("reset_test reached_idx4", int'(wait_cyc < 100), 1);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_values("mid_scan_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset no_done", int'(done), 0);
        end

        // Clean scan after the abort
        clear_stim();
        stim_re[3] = 1024; exp_mag[3] = 1024;
        run_frame("after_reset", 3, 1024, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
